// File: rtl/ftsd_scan_sched.sv
// Four-digit seven-segment scan scheduler with inter-digit blanking,
// double-buffered display data and optional leading-zero suppression.
module ftsd_scan_sched #(
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scan_tick,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  input  logic        lz_en,
  output logic [3:0]  ftsd_ctl,
  output logic [7:0]  ftsd_seg,
  output logic        frame_done
);

  typedef enum logic [0:0] {StDrive, StBlank} state_e;

  localparam logic [3:0] BlankLoad = 4'(BLANK_CYC - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] act_data_q, act_data_d, pend_data_q;
  logic [3:0]  act_dp_q, act_dp_d, pend_dp_q;
  logic        pend_valid_q, pend_valid_d;
  logic        commit, xfer;
  logic [3:0]  ctl_q, ctl_d;
  logic [7:0]  seg_q, seg_d;
  logic        frame_done_q;
  logic [15:0] shifted;
  logic        lz_blank;

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'h0: s = 8'h03;
      4'h1: s = 8'h9F;
      4'h2: s = 8'h25;
      4'h3: s = 8'h0D;
      4'h4: s = 8'h99;
      4'h5: s = 8'h49;
      4'h6: s = 8'h41;
      4'h7: s = 8'h1F;
      4'h8: s = 8'h01;
      4'h9: s = 8'h09;
      4'hA: s = 8'h11;
      4'hB: s = 8'hC1;
      4'hC: s = 8'h63;
      4'hD: s = 8'h85;
      4'hE: s = 8'h61;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  assign xfer     = wr_valid & ~pend_valid_q;
  assign wr_ready = ~pend_valid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    commit  = 1'b0;
    unique case (state_q)
      StDrive: begin
        if (scan_tick) begin
          state_d = StBlank;
          cnt_d   = BlankLoad;
        end
      end
      StBlank: begin
        if (cnt_q == 4'd0) begin
          state_d = StDrive;
          idx_d   = idx_q + 2'd1;
          commit  = (idx_q == 2'd3);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StBlank;
    endcase
  end

  // A commit cannot coincide with a transfer: a pending value holds wr_ready low.
  always_comb begin
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    pend_valid_d = pend_valid_q;
    if (commit && pend_valid_q) begin
      act_data_d   = pend_data_q;
      act_dp_d     = pend_dp_q;
      pend_valid_d = 1'b0;
    end else if (xfer) begin
      pend_valid_d = 1'b1;
    end
  end

  // Outputs are computed from next-state values so they register on the same edge.
  always_comb begin
    shifted  = act_data_d >> {idx_d, 2'b00};
    lz_blank = lz_en && (idx_d != 2'd0) && (shifted == 16'h0000);
    ctl_d    = 4'hF;
    seg_d    = 8'hFF;
    if (state_d == StDrive) begin
      ctl_d = ~(4'b0001 << idx_d);
      seg_d = lz_blank ? 8'hFF : hex_seg(shifted[3:0]);
      if (act_dp_d[idx_d]) seg_d[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StBlank;
      cnt_q        <= BlankLoad;
      idx_q        <= 2'd3;
      act_data_q   <= 16'h0000;
      act_dp_q     <= 4'h0;
      pend_data_q  <= 16'h0000;
      pend_dp_q    <= 4'h0;
      pend_valid_q <= 1'b0;
      ctl_q        <= 4'hF;
      seg_q        <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      pend_valid_q <= pend_valid_d;
      ctl_q        <= ctl_d;
      seg_q        <= seg_d;
      frame_done_q <= commit;
      if (xfer) begin
        pend_data_q <= wr_data;
        pend_dp_q   <= wr_dp;
      end
    end
  end

  assign ftsd_ctl   = ctl_q;
  assign ftsd_seg   = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ftsd_scan_sched.sv
// Scoreboard bench for ftsd_scan_sched: stimulus queues expected digit slots,
// a monitor pops and checks them as each slot starts on the display.
module tb_ftsd_scan_sched;

  localparam int BLANK = 2;
  localparam int DRIVE_LEN = 6;

  typedef struct packed {
    logic [3:0] ctl;
    logic [7:0] seg;
    logic       fd;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        scan_tick;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic        lz_en;
  logic [3:0]  ftsd_ctl;
  logic [7:0]  ftsd_seg;
  logic        frame_done;

  logic tick_auto, tick_extra, run_ticks, mon_en;
  int   total, bad, tcnt;
  exp_t exp_q[$];
  exp_t e_mon;
  int   in_drive, started, run, gap;

  assign scan_tick = tick_auto | tick_extra;

  ftsd_scan_sched #(.BLANK_CYC(BLANK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_tick  (scan_tick),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .lz_en      (lz_en),
    .ftsd_ctl   (ftsd_ctl),
    .ftsd_seg   (ftsd_seg),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    exp_q.push_back('{ctl: 4'hE, seg: s0, fd: 1'b1});
    exp_q.push_back('{ctl: 4'hD, seg: s1, fd: 1'b0});
    exp_q.push_back('{ctl: 4'hB, seg: s2, fd: 1'b0});
    exp_q.push_back('{ctl: 4'h7, seg: s3, fd: 1'b0});
  endtask

  task automatic wait_fd(input string name);
    bit got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_done) begin
        got = 1;
        break;
      end
    end
    if (!got) timeout(name);
  endtask

  task automatic wait_ctl(input logic [3:0] v, input string name);
    bit got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ftsd_ctl == v) begin
        got = 1;
        break;
      end
    end
    if (!got) timeout(name);
  endtask

  task automatic write_val(input logic [15:0] d, input logic [3:0] p, input string name);
    @(posedge clk);
    #1 wr_valid = 1'b1;
    wr_data = d;
    wr_dp   = p;
    @(posedge clk);
    #1 wr_valid = 1'b0;
    @(negedge clk);
    chk(name, wr_ready, 1'b0);
  endtask

  // Free-running tick every 8 cycles, aligned to reset release.
  initial begin
    tick_auto = 1'b0;
    tcnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!run_ticks) begin
        tcnt = 0;
        tick_auto = 1'b0;
      end else begin
        tcnt++;
        tick_auto = (tcnt % 8 == 0);
      end
    end
  end

  // Monitor: one queue entry per digit slot, plus slot and gap lengths.
  initial begin
    in_drive = 0; started = 0; run = 0; gap = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_drive = 0; started = 0; run = 0; gap = 0;
      end else if (ftsd_ctl != 4'hF) begin
        if (in_drive == 0) begin
          if (started != 0) chk("blank_gap", gap, BLANK);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_slot: got ctl=%h seg=%h, nothing queued", ftsd_ctl, ftsd_seg);
          end else begin
            e_mon = exp_q.pop_front();
            chk("slot_ctl", ftsd_ctl, e_mon.ctl);
            chk("slot_seg", ftsd_seg, e_mon.seg);
            chk("slot_frame_done", frame_done, e_mon.fd);
          end
          in_drive = 1;
          run = 1;
        end else begin
          run++;
        end
      end else begin
        if (in_drive != 0) begin
          chk("drive_len", run, DRIVE_LEN);
          in_drive = 0;
          started = 1;
          gap = 1;
        end else begin
          gap++;
        end
      end
    end
  end

  initial begin
    logic early, prev, got;
    total = 0; bad = 0;
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = 16'h0; wr_dp = 4'h0; lz_en = 1'b0;
    run_ticks = 1'b0; mon_en = 1'b0; tick_extra = 1'b0;
    #12;
    chk("rst_ctl", ftsd_ctl, 4'hF);
    chk("rst_seg", ftsd_seg, 8'hFF);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b1);

    // Frame 0 shows the reset value 0000.
    push_frame(8'h03, 8'h03, 8'h03, 8'h03);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_ticks = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rel1_ctl", ftsd_ctl, 4'hF);
    chk("rel1_frame_done", frame_done, 1'b0);
    @(negedge clk);
    chk("rel2_ctl", ftsd_ctl, 4'hE);
    chk("rel2_seg", ftsd_seg, 8'h03);
    chk("rel2_frame_done", frame_done, 1'b1);

    // Written during frame 0, visible from frame 1.
    write_val(16'h1234, 4'b0100, "w1234_pending");
    push_frame(8'h99, 8'h0D, 8'h24, 8'h9F);

    wait_fd("fd_f1");
    write_val(16'h0050, 4'b0000, "w0050_pending");
    lz_en = 1'b1;
    push_frame(8'h03, 8'h49, 8'hFF, 8'hFF);

    // Second write held against a full pending slot.
    @(posedge clk);
    #1 wr_valid = 1'b1;
    wr_data = 16'h8E7C;
    wr_dp   = 4'b1001;
    early = 1'b0; prev = 1'b0; got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_done) begin
        got = 1'b1;
        break;
      end
      if (wr_ready) early = 1'b1;
      prev = wr_ready;
    end
    if (got) begin
      chk("hold_ready_low", early, 1'b0);
      chk("commit_cycle_ready", prev, 1'b0);
      chk("ready_after_commit", wr_ready, 1'b1);
    end else begin
      timeout("fd_f2");
    end
    @(posedge clk);
    #1 wr_valid = 1'b0;
    @(negedge clk);
    chk("second_accepted", wr_ready, 1'b0);
    push_frame(8'h62, 8'h1F, 8'h61, 8'h00);

    wait_fd("fd_f3");
    lz_en = 1'b0;
    write_val(16'h0050, 4'b0000, "w0050b_pending");
    push_frame(8'h03, 8'h49, 8'h03, 8'h03);

    // Extra ticks while blanking and on the blank-to-drive cycle must be ignored.
    wait_fd("fd_f4");
    push_frame(8'h03, 8'h49, 8'h03, 8'h03);
    wait_ctl(4'hF, "blank_f4");
    tick_extra = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 tick_extra = 1'b0;

    // Reset during digit 2 with a pending value that must never appear.
    wait_fd("fd_f5");
    write_val(16'hFFFF, 4'hF, "wffff_pending");
    wait_ctl(4'hB, "digit2_f5");
    #2 rst_n = 1'b0;
    run_ticks = 1'b0;
    mon_en = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_ctl", ftsd_ctl, 4'hF);
    chk("mid_rst_seg", ftsd_seg, 8'hFF);
    chk("mid_rst_wr_ready", wr_ready, 1'b1);
    chk("mid_rst_frame_done", frame_done, 1'b0);

    push_frame(8'h03, 8'h03, 8'h03, 8'h03);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_ticks = 1'b1;
    mon_en = 1'b1;
    wait_fd("fd_r0");
    push_frame(8'h03, 8'h03, 8'h03, 8'h03);
    wait_fd("fd_r1");

    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) timeout("drain_queue");
    repeat (2) @(negedge clk);
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
